// File: rtl/integrator_dump_mc.sv
// integrator_dump_mc
// Multi-channel integrate-and-dump. Signed samples arrive time-multiplexed
// by channel. Each channel accumulates its own samples and, after DUMP_LEN
// accepted samples, hands the sum to a single-entry output slot. It then
// restarts from zero. Adds are saturating (SATURATE=1) or wrap (SATURATE=0).
// Either way, any overflow inside a window is reported with that window's
// result.
//
// Ports:
//   system1000       clock, rising edge
//   system1000_rstn  asynchronous active-low reset
//   clear            synchronous clear of all channel state and the output slot
//   in_valid/in_ready/in_ch/in_data      sample handshake
//   out_valid/out_ready/out_ch/out_data/out_sat  dump result handshake

// One channel's accumulator, sample counter and overflow flag.
// The lane exposes the would-be sum combinationally, so the top can capture
// it on the dump sample without an extra cycle.
module integrator_dump_mc_lane #(
    parameter int IN_WIDTH  = 10,
    parameter int ACC_WIDTH = 16,
    parameter int DUMP_LEN  = 8,
    parameter int SATURATE  = 1
) (
    input  logic                        system1000,
    input  logic                        system1000_rstn,
    input  logic                        clear,
    input  logic                        acc_en,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        dump,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        sat_win
);
    localparam int CNT_W = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DUMP_LEN - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]            cnt;
    logic                        sat;
    logic signed [ACC_WIDTH:0]   wide;
    logic                        ovf;

    always_comb begin
        // One guard bit is enough: one sample can never push a sum past
        // twice the accumulator range.
        wide = {acc[ACC_WIDTH-1], acc}
             + {{(ACC_WIDTH+1-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
        sum  = wide[ACC_WIDTH-1:0];
        if (ovf && SATURATE != 0)
            sum = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        dump    = acc_en & (cnt == LAST);
        sat_win = sat | ovf;
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (acc_en) begin
            if (cnt == LAST) begin
                acc <= '0;
                cnt <= '0;
                sat <= 1'b0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                sat <= sat | ovf;
            end
        end
    end
endmodule

module integrator_dump_mc #(
    parameter int IN_WIDTH  = 10,
    parameter int ACC_WIDTH = 16,
    parameter int CHANNELS  = 4,
    parameter int DUMP_LEN  = 8,
    parameter int SATURATE  = 1,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        system1000,
    input  logic                        system1000_rstn,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CH_W-1:0]             in_ch,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CH_W-1:0]             out_ch,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic                        out_sat
);
    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [ACC_WIDTH-1:0] data;
        logic                 sat;
    } result_t;

    typedef enum logic {EMPTY, FULL} slot_e;

    slot_e   state_q, state_d;
    result_t dump_res, out_q;
    logic    load;
    logic    accept;
    logic    dump_any;

    logic [CHANNELS-1:0]                lane_en;
    logic [CHANNELS-1:0]                lane_dump;
    logic [CHANNELS-1:0]                lane_sat;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] lane_sum;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !clear & (!out_valid | out_ready);
    assign accept    = in_valid & in_ready;

    // Channel indices past CHANNELS-1 match no lane, so they are consumed
    // without touching any state.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        assign lane_en[g] = accept & (in_ch == CH_W'(g));

        integrator_dump_mc_lane #(
            .IN_WIDTH (IN_WIDTH),
            .ACC_WIDTH(ACC_WIDTH),
            .DUMP_LEN (DUMP_LEN),
            .SATURATE (SATURATE)
        ) u_lane (
            .system1000     (system1000),
            .system1000_rstn(system1000_rstn),
            .clear          (clear),
            .acc_en         (lane_en[g]),
            .in_data        (in_data),
            .dump           (lane_dump[g]),
            .sum            (lane_sum[g]),
            .sat_win        (lane_sat[g])
        );
    end

    // At most one lane is enabled per cycle, so the dump mux is a plain
    // one-hot select.
    always_comb begin
        dump_any = |lane_dump;
        dump_res = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (lane_dump[i]) begin
                dump_res.ch   = CH_W'(i);
                dump_res.data = lane_sum[i];
                dump_res.sat  = lane_sat[i];
            end
        end
    end

    // A dump while FULL is only possible when out_ready drains the slot in
    // the same cycle, because in_ready holds off samples otherwise. A new
    // result therefore never overwrites one that has not been taken.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (clear) begin
            state_d = EMPTY;
        end else if (dump_any) begin
            state_d = FULL;
            load    = 1'b1;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clear)
                out_q <= '0;
            else if (load)
                out_q <= dump_res;
        end
    end

    assign out_ch   = out_q.ch;
    assign out_data = out_q.data;
    assign out_sat  = out_q.sat;
endmodule

// File: tb/tb_integrator_dump_mc.sv
module tb_integrator_dump_mc;
    // Four DUTs sharing clock and reset:
    //   0: defaults
    //   1: ACC 11, 3 channels, dump 4, saturate
    //   2: ACC 11, 4 channels, dump 4, wrap
    //   3: 1 channel, dump 1
    localparam int N = 4;
    localparam int AW  [N] = '{16, 11, 11, 16};
    localparam int NCH [N] = '{4, 3, 4, 1};
    localparam int DL  [N] = '{8, 4, 4, 1};
    localparam int SM  [N] = '{1, 1, 0, 1};

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic iv[N], clr[N], ordy[N], irdy[N], ov[N], osat[N];
    logic [1:0] ich[N];
    logic [9:0] idat[N];
    logic [1:0] och0, och1, och2;
    logic       och3;
    logic [15:0] od0, od3;
    logic [10:0] od1, od2;

    integrator_dump_mc #(.IN_WIDTH(10), .ACC_WIDTH(16), .CHANNELS(4), .DUMP_LEN(8), .SATURATE(1)) u0 (
        .system1000(clk), .system1000_rstn(rstn), .clear(clr[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_ch(ich[0]), .in_data(idat[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_ch(och0),
        .out_data(od0), .out_sat(osat[0]));
    integrator_dump_mc #(.IN_WIDTH(10), .ACC_WIDTH(11), .CHANNELS(3), .DUMP_LEN(4), .SATURATE(1)) u1 (
        .system1000(clk), .system1000_rstn(rstn), .clear(clr[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_ch(ich[1]), .in_data(idat[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_ch(och1),
        .out_data(od1), .out_sat(osat[1]));
    integrator_dump_mc #(.IN_WIDTH(10), .ACC_WIDTH(11), .CHANNELS(4), .DUMP_LEN(4), .SATURATE(0)) u2 (
        .system1000(clk), .system1000_rstn(rstn), .clear(clr[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_ch(ich[2]), .in_data(idat[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_ch(och2),
        .out_data(od2), .out_sat(osat[2]));
    integrator_dump_mc #(.IN_WIDTH(10), .ACC_WIDTH(16), .CHANNELS(1), .DUMP_LEN(1), .SATURATE(1)) u3 (
        .system1000(clk), .system1000_rstn(rstn), .clear(clr[3]), .in_valid(iv[3]), .in_ready(irdy[3]),
        .in_ch(ich[3][0]), .in_data(idat[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_ch(och3),
        .out_data(od3), .out_sat(osat[3]));

    function automatic longint get_od(input int k);
        case (k)
            0:       return longint'($signed(od0));
            1:       return longint'($signed(od1));
            2:       return longint'($signed(od2));
            default: return longint'($signed(od3));
        endcase
    endfunction

    function automatic longint get_och(input int k);
        case (k)
            0:       return longint'(och0);
            1:       return longint'(och1);
            2:       return longint'(och2);
            default: return longint'(och3);
        endcase
    endfunction

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: plain integer sums per channel plus one pending result.
    longint macc[N][4];
    int     mcnt[N][4];
    bit     msat[N][4];
    bit     ev[N];
    int     ech[N];
    longint ed[N];
    bit     es[N];

    typedef struct {
        int     k;
        int     ch;
        longint d;
        bit     s;
    } res_t;
    res_t logq[$];

    task automatic mreset(input int k);
        for (int c = 0; c < 4; c++) begin
            macc[k][c] = 0;
            mcnt[k][c] = 0;
            msat[k][c] = 0;
        end
        ev[k] = 0;
        ech[k] = 0;
        ed[k] = 0;
        es[k] = 0;
    endtask

    always @(negedge clk) begin
        longint sum, hi, lo;
        bit of, rdy;
        int c;
        res_t r;
        for (int k = 0; k < N; k++) begin
            if (!rstn) begin
                mreset(k);
                chk($sformatf("rst_valid%0d", k), longint'(ov[k]), 0);
                chk($sformatf("rst_data%0d", k), get_od(k), 0);
                chk($sformatf("rst_sat%0d", k), longint'(osat[k]), 0);
                chk($sformatf("rst_ch%0d", k), get_och(k), 0);
            end else begin
                rdy = !clr[k] && (!ev[k] || ordy[k]);
                chk($sformatf("out_valid%0d", k), longint'(ov[k]), longint'(ev[k]));
                chk($sformatf("in_ready%0d", k), longint'(irdy[k]), longint'(rdy));
                if (ev[k]) begin
                    chk($sformatf("out_ch%0d", k), get_och(k), longint'(ech[k]));
                    chk($sformatf("out_data%0d", k), get_od(k), ed[k]);
                    chk($sformatf("out_sat%0d", k), longint'(osat[k]), longint'(es[k]));
                end
                if (clr[k]) begin
                    mreset(k);
                end else begin
                    if (ev[k] && ordy[k]) begin
                        r.k = k;
                        r.ch = ech[k];
                        r.d = ed[k];
                        r.s = es[k];
                        logq.push_back(r);
                        ev[k] = 0;
                    end
                    if (iv[k] && rdy && int'(ich[k]) < NCH[k]) begin
                        c = int'(ich[k]);
                        hi = (64'sd1 <<< (AW[k] - 1)) - 1;
                        lo = -hi - 1;
                        sum = macc[k][c] + longint'($signed(idat[k]));
                        of = (sum > hi) || (sum < lo);
                        if (of) begin
                            if (SM[k] != 0)
                                sum = (sum > hi) ? hi : lo;
                            else
                                sum = (sum > hi) ? sum - (hi - lo + 1) : sum + (hi - lo + 1);
                        end
                        if (mcnt[k][c] == DL[k] - 1) begin
                            ev[k] = 1;
                            ech[k] = c;
                            ed[k] = sum;
                            es[k] = msat[k][c] | of;
                            macc[k][c] = 0;
                            mcnt[k][c] = 0;
                            msat[k][c] = 0;
                        end else begin
                            macc[k][c] = sum;
                            mcnt[k][c]++;
                            msat[k][c] = msat[k][c] | of;
                        end
                    end
                end
            end
        end
    end

    // Present one sample and hold it until the DUT accepts it.
    // iv stays high afterwards so that consecutive calls run back-to-back.
    task automatic send(input int k, input int ch, input int d);
        bit r;
        int t;
        r = 0;
        t = 0;
        iv[k] = 1;
        ich[k] = 2'(ch);
        idat[k] = 10'(d);
        while (!r && t < 100) begin
            @(negedge clk);
            r = irdy[k];
            @(posedge clk);
            #1;
            t++;
        end
        if (!r) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout%0d: in_ready got 0 expected 1", k);
        end
    endtask

    task automatic idle(input int k, input int n);
        iv[k] = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string nm, input int k, input int ch, input longint d, input bit s);
        res_t r;
        if (logq.size() == 0) begin
            chk({nm, "_count"}, 0, 1);
        end else begin
            r = logq.pop_front();
            chk({nm, "_inst"}, r.k, k);
            chk({nm, "_ch"}, r.ch, ch);
            chk({nm, "_data"}, r.d, d);
            chk({nm, "_sat"}, longint'(r.s), longint'(s));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: finished got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            iv[k] = 0;
            clr[k] = 0;
            ordy[k] = 1;
            ich[k] = 0;
            idat[k] = 0;
        end
        repeat (3) @(posedge clk);
        #3 rstn = 1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("post_rst_ready%0d", k), longint'(irdy[k]), 1);
            chk($sformatf("post_rst_valid%0d", k), longint'(ov[k]), 0);
        end

        // Channel 0 ramp, then a fresh window from zero.
        for (int i = 1; i <= 8; i++) send(0, 0, i);
        idle(0, 3);
        expect_res("ramp", 0, 0, 36, 0);
        chk("ramp_single", logq.size(), 0);
        for (int i = 1; i <= 8; i++) send(0, 0, i);
        idle(0, 3);
        expect_res("ramp2", 0, 0, 36, 0);

        // Interleaved channels complete in order.
        for (int i = 0; i < 8; i++) begin
            send(0, 0, 100);
            send(0, 1, -3);
        end
        idle(0, 3);
        expect_res("ilv0", 0, 0, 800, 0);
        expect_res("ilv1", 0, 1, -24, 0);

        // Saturating: an out-of-range channel is ignored, then the clamp applies, then a clean window.
        send(1, 3, 100);
        for (int i = 0; i < 4; i++) send(1, 2, 511);
        idle(1, 3);
        expect_res("satclamp", 1, 2, 1023, 1);
        for (int i = 0; i < 4; i++) send(1, 2, 1);
        idle(1, 3);
        expect_res("satclean", 1, 2, 4, 0);

        // Wrapping arithmetic.
        for (int i = 0; i < 4; i++) send(2, 2, 511);
        idle(2, 3);
        expect_res("wrap", 2, 2, -4, 1);

        // Backpressure: the pending result holds, and the waiting sample is not lost.
        ordy[0] = 0;
        for (int i = 0; i < 8; i++) send(0, 0, 1);
        ich[0] = 0;
        idat[0] = 10'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_ready", longint'(irdy[0]), 0);
            chk("stall_valid", longint'(ov[0]), 1);
            chk("stall_data", get_od(0), 8);
            @(posedge clk);
            #1;
        end
        ordy[0] = 1;
        send(0, 0, 9);
        for (int i = 0; i < 7; i++) send(0, 0, 1);
        idle(0, 3);
        expect_res("stall_a", 0, 0, 8, 0);
        expect_res("stall_b", 0, 0, 16, 0);

        // A clear in mid-window discards the partial sum.
        for (int i = 0; i < 3; i++) send(0, 3, 50);
        idle(0, 1);
        clr[0] = 1;
        @(posedge clk);
        #1;
        clr[0] = 0;
        for (int i = 0; i < 8; i++) send(0, 3, 1);
        idle(0, 3);
        expect_res("clear", 0, 3, 8, 0);

        // DUMP_LEN=1: every accepted sample dumps, and channel 1 is out of range.
        send(3, 0, -5);
        send(3, 0, 7);
        send(3, 1, 9);
        send(3, 0, 511);
        send(3, 0, -512);
        idle(3, 3);
        expect_res("dl1_a", 3, 0, -5, 0);
        expect_res("dl1_b", 3, 0, 7, 0);
        expect_res("dl1_c", 3, 0, 511, 0);
        expect_res("dl1_d", 3, 0, -512, 0);

        // Asynchronous reset with a result pending.
        ordy[0] = 0;
        for (int i = 0; i < 8; i++) send(0, 2, 2);
        idle(0, 2);
        chk("pend_valid", longint'(ov[0]), 1);
        #2 rstn = 0;
        #1;
        chk("arst_valid", longint'(ov[0]), 0);
        chk("arst_data", get_od(0), 0);
        chk("arst_sat", longint'(osat[0]), 0);
        chk("arst_ch", get_och(0), 0);
        repeat (2) @(posedge clk);
        #3 rstn = 1;
        ordy[0] = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send(0, 2, 1);
        idle(0, 3);
        expect_res("post_arst", 0, 2, 8, 0);
        chk("log_empty", logq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
